jregbank: RTL and testbench
===========================

// Module: jregbank
// PURPOSE
//  Parametrised register bank: NREG registers of W bits on a shared data bus,
//  with decoder-selected write ("set") and read ("enable") ports.
//  Generalises the single 8-bit enabler/bus1 path to N registers, width W,
//  independent set/enable addresses and an integrated bus1 mode.
//  Sits between the CPU bus and the ALU/TMP path as the general-purpose register set.
// PARAMETERS
//  W     8   data width in bits (>=2)
//  NREG  4   number of registers (>=2; need not be a power of two)
//  A     2   address width; must satisfy 2**A >= NREG (checked at elaboration)
// PORTS
//  wclk    in   1     clock; state changes on rising edge only
//  wrst_n  in   1     asynchronous reset, active low; clears all registers
//  bis     in   W     write data from bus
//  wset    in   1     write strobe; register bsa captures bis at rising wclk
//  bsa     in   A     set (write) address
//  wena    in   1     read enable; gates selected register onto bos
//  bea     in   A     enable (read) address
//  wbit1   in   1     bus1 mode: force bos to constant 1 (bit0=1, others 0)
//  bos     out  W     read data to bus
// BEHAVIOUR
//  - Reset: wrst_n=0 clears every register to 0 immediately, independent of wclk;
//    bos follows combinationally (0, or 1 if wbit1). Writes ignored while wrst_n=0.
//  - Reset release: first write possible on first rising wclk with wrst_n=1.
//  - Write: on rising wclk with wset=1 and bsa<NREG, reg[bsa] <= bis. Exactly one
//    register updates; all others hold. wset=0: no register changes.
//  - Out-of-range: bsa>=NREG write is dropped; bea>=NREG reads as 0.
//  - Read (combinational, no clock latency):
//      wbit1=1            -> bos = {W-1 zeros, 1}   (overrides wena/bea)
//      wbit1=0, wena=1    -> bos = reg[bea]
//      wbit1=0, wena=0    -> bos = 0
//  - Read-during-write, same address: bos shows old value until the edge,
//    new value after the edge settles. No bypass of bis to bos.
//  - bsa/bea/bis/wset must be stable for setup/hold around rising wclk;
//    all gate-level paths settle within the bench's half-period (#1 per nand).
//  - Simultaneous wbit1 and write: write still occurs; only bos is forced.
//  - No other state: no FSM beyond the per-register storage.
// STRUCTURE
//  - Shared include (jdefs.vh): default W, NREG, clog2 helper, bus1 constant.
//  - One sub-module: jregw #(W) -- W-bit register, write enable, async clear,
//    built from the library memory-bit cell; instantiated NREG times.
//  - Write select: jdecoder #(A,2**A) on bsa, each output AND wset -> jregw enable.
//  - Read select: jdecoder on bea, each output AND wena -> jenabler per register;
//    enabler outputs OR-reduced per bit (jorN #(NREG)), then jbus1 stage on wbit1.
// TESTING
//  1. wrst_n=0 mid-run after loading regs -> all reads 0 immediately; bos=0 with
//     wena=1, no wclk edge required.
//  2. Write 8'hA5 to r0, 8'h3C to r3, read r0,r3,r1 -> 8'hA5, 8'h3C, 8'h00.
//  3. wena=1 bea=2, write 8'h77 to r2 same cycle (old 8'h11) -> bos 8'h11 before
//     edge, 8'h77 after.
//  4. wbit1=1, wena=1 bea=0 (r0=8'hFF) -> bos=8'h01; drop wbit1 -> 8'hFF.
//  5. NREG=3,A=2: write 8'hEE at bsa=3 -> no reg changes; read bea=3 -> 8'h00.
//  6. W=16,NREG=8 sweep: write 16'h1000+i to each ri, read back all -> exact match.

Source files
------------

// File: rtl/jregbank_pkg.sv
// Shared definitions for the general-purpose register bank: default
// geometry, read-mode encoding and small helpers used by the top level.
package jregbank_pkg;

    localparam int DEF_W    = 8;
    localparam int DEF_NREG = 4;
    localparam int DEF_A    = 2;

    // Source selected onto the output bus
    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,   // bus driven to zero
        RD_REG  = 2'd1,   // addressed register
        RD_BUS1 = 2'd2    // constant one (bus1 mode)
    } rdmode_t;

    // Smallest address width able to index n registers
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // bus1 mode has priority over the read enable
    function automatic rdmode_t rd_mode(input logic bit1, input logic ena);
        if (bit1)
            return RD_BUS1;
        else if (ena)
            return RD_REG;
        else
            return RD_IDLE;
    endfunction

endpackage

// File: rtl/jregbank_jregw.sv
// W-bit storage register with write enable and asynchronous clear.
// One instance per entry of the register bank.
module jregw #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d on enabled rising edges; clear immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/jregbank.sv
// General-purpose register bank: NREG registers of W bits sharing one
// input bus and one output bus, with independent write and read addresses
// and a bus1 mode that forces the constant 1 onto the output.
module jregbank
    import jregbank_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int NREG = DEF_NREG,
    parameter int A    = DEF_A
) (
    input  logic         wclk,
    input  logic         wrst_n,
    input  logic [W-1:0] bis,
    input  logic         wset,
    input  logic [A-1:0] bsa,
    input  logic         wena,
    input  logic [A-1:0] bea,
    input  logic         wbit1,
    output logic [W-1:0] bos
);

    // Reject geometries the address decoders cannot cover
    if (((1 << A) < NREG) || (W < 2) || (NREG < 2)) begin : g_param_check
        $fatal(1, "jregbank: need W>=2, NREG>=2 and 2**A >= NREG");
    end

    logic [W-1:0]    q [NREG];
    logic [NREG-1:0] wsel;
    logic [NREG-1:0] rsel;
    logic [W-1:0]    ored;

    // Decoded write/read selects; addresses >= NREG match no entry, so
    // out-of-range writes are dropped and out-of-range reads give zero
    for (genvar i = 0; i < NREG; i++) begin : g_reg
        assign wsel[i] = wset & (bsa == A'(i));
        assign rsel[i] = wena & (bea == A'(i));

        jregw #(.W(W)) u_reg (
            .clk   (wclk),
            .rst_n (wrst_n),
            .en    (wsel[i]),
            .d     (bis),
            .q     (q[i])
        );
    end

    // OR-combine the gated register outputs (at most one is selected)
    always_comb begin
        ored = '0;
        for (int i = 0; i < NREG; i++) begin
            if (rsel[i])
                ored = ored | q[i];
        end
    end

    // Final output stage: bus1 constant overrides the register path
    always_comb begin
        bos = '0;
        unique case (rd_mode(wbit1, wena))
            RD_BUS1: bos = W'(1);
            RD_REG:  bos = ored;
            default: bos = '0;
        endcase
    end

endmodule

// File: tb/tb_jregbank.sv
// Directed bench for jregbank: a default 8x4 bank, a 3-entry bank with an
// unused address, and a 16x8 bank, all sharing clock, reset and buses.
module tb_jregbank;

    logic        wclk;
    logic        wrst_n;
    logic [15:0] bis;
    logic [2:0]  bsa;
    logic [2:0]  bea;
    logic        wena;
    logic        wbit1;
    logic        wset0, wset1, wset2;
    logic [7:0]  bos0, bos1;
    logic [15:0] bos2;

    int total;
    int fails;

    jregbank #(.W(8), .NREG(4), .A(2)) d0 (
        .wclk(wclk), .wrst_n(wrst_n), .bis(bis[7:0]), .wset(wset0),
        .bsa(bsa[1:0]), .wena(wena), .bea(bea[1:0]), .wbit1(wbit1), .bos(bos0)
    );

    jregbank #(.W(8), .NREG(3), .A(2)) d1 (
        .wclk(wclk), .wrst_n(wrst_n), .bis(bis[7:0]), .wset(wset1),
        .bsa(bsa[1:0]), .wena(wena), .bea(bea[1:0]), .wbit1(wbit1), .bos(bos1)
    );

    jregbank #(.W(16), .NREG(8), .A(3)) d2 (
        .wclk(wclk), .wrst_n(wrst_n), .bis(bis), .wset(wset2),
        .bsa(bsa), .wena(wena), .bea(bea), .wbit1(wbit1), .bos(bos2)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One write to bank `dut`; inputs change on falling edges only
    task automatic wr(input int dut, input logic [2:0] a, input logic [15:0] d);
        @(negedge wclk);
        bsa = a;
        bis = d;
        case (dut)
            0: wset0 = 1'b1;
            1: wset1 = 1'b1;
            default: wset2 = 1'b1;
        endcase
        @(negedge wclk);
        wset0 = 1'b0;
        wset1 = 1'b0;
        wset2 = 1'b0;
    endtask

    // Combinational read: set address/enable, let it settle
    task automatic rd(input logic [2:0] a);
        bea  = a;
        wena = 1'b1;
        #1;
    endtask

    initial begin
        total  = 0;
        fails  = 0;
        wrst_n = 1'b0;
        bis    = '0;
        bsa    = '0;
        bea    = '0;
        wena   = 1'b1;
        wbit1  = 1'b0;
        wset0  = 1'b0;
        wset1  = 1'b0;
        wset2  = 1'b0;

        // Reset state
        #2;
        check("reset_d0", {8'h00, bos0}, 16'h0000);
        check("reset_d2", bos2, 16'h0000);
        @(negedge wclk);
        wrst_n = 1'b1;

        // Basic writes and reads
        wr(0, 3'd0, 16'h00A5);
        wr(0, 3'd3, 16'h003C);
        rd(3'd0); check("r0_a5", {8'h00, bos0}, 16'h00A5);
        rd(3'd3); check("r3_3c", {8'h00, bos0}, 16'h003C);
        rd(3'd1); check("r1_00", {8'h00, bos0}, 16'h0000);
        wena = 1'b0; #1;
        check("wena0", {8'h00, bos0}, 16'h0000);

        // wset=0 leaves registers unchanged
        @(negedge wclk);
        bsa = 3'd0; bis = 16'h0099;
        @(negedge wclk);
        rd(3'd0); check("noset_r0", {8'h00, bos0}, 16'h00A5);

        // Read during write to the same address
        wr(0, 3'd2, 16'h0011);
        bea = 3'd2; wena = 1'b1; bsa = 3'd2; bis = 16'h0077; wset0 = 1'b1;
        #1;
        check("rdw_before", {8'h00, bos0}, 16'h0011);
        @(posedge wclk); #1;
        check("rdw_after", {8'h00, bos0}, 16'h0077);
        @(negedge wclk);
        wset0 = 1'b0;

        // bus1 mode
        wr(0, 3'd0, 16'h00FF);
        rd(3'd0); wbit1 = 1'b1; #1;
        check("bus1_on", {8'h00, bos0}, 16'h0001);
        wena = 1'b0; #1;
        check("bus1_noena", {8'h00, bos0}, 16'h0001);
        wena = 1'b1; wbit1 = 1'b0; #1;
        check("bus1_off", {8'h00, bos0}, 16'h00FF);

        // Write while bus1 forced still lands
        wbit1 = 1'b1;
        wr(0, 3'd1, 16'h005A);
        wbit1 = 1'b0;
        rd(3'd1); check("bus1_write", {8'h00, bos0}, 16'h005A);

        // Asynchronous reset mid-cycle, no clock edge needed
        rd(3'd0);
        #2;
        wrst_n = 1'b0;
        #1;
        check("arst_r0", {8'h00, bos0}, 16'h0000);
        rd(3'd3); check("arst_r3", {8'h00, bos0}, 16'h0000);
        wbit1 = 1'b1; #1;
        check("arst_bus1", {8'h00, bos0}, 16'h0001);
        wbit1 = 1'b0;
        // Writes ignored while held in reset
        wr(0, 3'd1, 16'h0042);
        rd(3'd1); check("arst_nowrite", {8'h00, bos0}, 16'h0000);
        @(negedge wclk);
        wrst_n = 1'b1;
        wr(0, 3'd1, 16'h0042);
        rd(3'd1); check("post_rst_write", {8'h00, bos0}, 16'h0042);

        // Three-entry bank: address 3 is out of range
        wr(1, 3'd0, 16'h0001);
        wr(1, 3'd1, 16'h0002);
        wr(1, 3'd2, 16'h0003);
        wr(1, 3'd3, 16'h00EE);
        rd(3'd0); check("n3_r0", {8'h00, bos1}, 16'h0001);
        rd(3'd1); check("n3_r1", {8'h00, bos1}, 16'h0002);
        rd(3'd2); check("n3_r2", {8'h00, bos1}, 16'h0003);
        rd(3'd3); check("n3_oor", {8'h00, bos1}, 16'h0000);

        // Wide bank sweep
        for (int i = 0; i < 8; i++)
            wr(2, 3'(i), 16'h1000 + 16'(i));
        for (int i = 0; i < 8; i++) begin
            rd(3'(i));
            check($sformatf("w16_r%0d", i), bos2, 16'h1000 + 16'(i));
        end
        wbit1 = 1'b1; #1;
        check("w16_bus1", bos2, 16'h0001);
        wbit1 = 1'b0;

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
